reduce_accum: RTL

REDUCE_ACCUM -- requirements
Module: reduce_accum

---
 rtl/reduce_pkg.sv | 7 +
 rtl/reduce_word.sv | 13 +
 rtl/reduce_accum.sv | 111 +++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// reduce_pkg: FSM state encoding and accumulator identity values shared by reduce_accum.
package reduce_pkg;
    typedef enum logic {ACC = 1'b0, RESULT = 1'b1} state_t;
    localparam logic AND_ID = 1'b1;
    localparam logic OR_ID  = 1'b0;
    localparam logic XOR_ID = 1'b0;
endpackage

// File: rtl/reduce_word.sv
// reduce_word: combinational AND/OR/XOR reduction of one input word.
module reduce_word #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] word_i,
    output logic             and_o,
    output logic             or_o,
    output logic             xor_o
);
    assign and_o = &word_i;
    assign or_o  = |word_i;
    assign xor_o = ^word_i;
endmodule

// File: rtl/reduce_accum.sv
// reduce_accum: per-packet AND/OR/XOR reduction and saturating beat count with a valid/ready result.
module reduce_accum
    import reduce_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_1,
    output logic             out_2,
    output logic             out_3,
    output logic [CNT_W-1:0] out_cnt
);
    state_t             state_q, state_d;
    logic               and_q, and_d, or_q, or_d, xor_q, xor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic [CNT_W-1:0]   outcnt_q, outcnt_d;
    logic               w_and, w_or, w_xor;
    logic               and_n, or_n, xor_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               accept, handshake;

    reduce_word #(.WIDTH(WIDTH)) u_word (
        .word_i (in_1),
        .and_o  (w_and),
        .or_o   (w_or),
        .xor_o  (w_xor)
    );

    assign in_ready  = resetn && (state_q == ACC);
    assign out_valid = resetn && (state_q == RESULT);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign out_1     = out1_q;
    assign out_2     = out2_q;
    assign out_3     = out3_q;
    assign out_cnt   = outcnt_q;

    // Values including the current beat; count sticks at all-ones.
    assign and_n = and_q & w_and;
    assign or_n  = or_q | w_or;
    assign xor_n = xor_q ^ w_xor;
    assign cnt_n = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        and_d    = and_q;
        or_d     = or_q;
        xor_d    = xor_q;
        cnt_d    = cnt_q;
        out1_d   = out1_q;
        out2_d   = out2_q;
        out3_d   = out3_q;
        outcnt_d = outcnt_q;
        if (accept && in_last) begin
            out1_d   = and_n;
            out2_d   = or_n;
            out3_d   = xor_n;
            outcnt_d = cnt_n;
            and_d    = AND_ID;
            or_d     = OR_ID;
            xor_d    = XOR_ID;
            cnt_d    = '0;
            state_d  = RESULT;
        end else if (accept) begin
            and_d = and_n;
            or_d  = or_n;
            xor_d = xor_n;
            cnt_d = cnt_n;
        end
        if (handshake) begin
            and_d   = AND_ID;
            or_d    = OR_ID;
            xor_d   = XOR_ID;
            cnt_d   = '0;
            state_d = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ACC;
            and_q    <= AND_ID;
            or_q     <= OR_ID;
            xor_q    <= XOR_ID;
            cnt_q    <= '0;
            out1_q   <= 1'b0;
            out2_q   <= 1'b0;
            out3_q   <= 1'b0;
            outcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            and_q    <= and_d;
            or_q     <= or_d;
            xor_q    <= xor_d;
            cnt_q    <= cnt_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            out3_q   <= out3_d;
            outcnt_q <= outcnt_d;
        end
    end
endmodule
